// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM for the multicycle RV32I datapath.
// It decodes the latched opcode and steps through fetch / decode / execute /
// memory / writeback. It also drives every datapath select and enable.
// A memory-wait watchdog sends the FSM to a halt (TRAP) state when
// mem_ready stays low for too long.
// Optional feature macro: ILLEGAL_TRAP_EN. When it is defined, unsupported
// opcodes and unsupported branch funct3 values trap and set illegal_instr.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = $clog2(MEM_TIMEOUT + 1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       mem_timeout,
  output logic       illegal_instr,
  output logic       halted
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR1    = 4'd11,
    S_JALR2    = 4'd12,
    S_LUI      = 4'd13,
    S_AUIPC    = 4'd14,
    S_TRAP     = 4'd15
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [1:0] A_PC    = 2'b00;
  localparam logic [1:0] A_OLDPC = 2'b01;
  localparam logic [1:0] A_RS1   = 2'b10;
  localparam logic [1:0] A_ZERO  = 2'b11;
  localparam logic [1:0] B_RS2   = 2'b00;
  localparam logic [1:0] B_IMM   = 2'b01;
  localparam logic [1:0] B_FOUR  = 2'b10;
  localparam logic [1:0] R_ALUOUT = 2'b00;
  localparam logic [1:0] R_DATA   = 2'b01;
  localparam logic [1:0] R_ALURES = 2'b10;
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_FUNC = 2'b10;

  // cnt_q counts the wait cycles already spent before the current one.
  // The watchdog therefore fires on the MEM_TIMEOUT-th consecutive cycle
  // without mem_ready.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MEM_TIMEOUT);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q;
  logic             wait_st;
  logic             timeout_hit;
  logic             br_taken;
`ifdef ILLEGAL_TRAP_EN
  logic             illegal_q;
  logic             illegal_set;
`endif

  assign wait_st     = (state_q == S_FETCH) || (state_q == S_MEMREAD) ||
                       (state_q == S_MEMWRITE);
  assign timeout_hit = wait_st && !mem_ready && (cnt_q == CNT_LAST);
  assign br_taken    = ((funct3 == F3_BEQ) && zero) ||
                       ((funct3 == F3_BNE) && !zero);

  // Wait counter: cleared outside wait states and on mem_ready; saturates.
  // Every entry into a wait state comes either from a non-wait state or
  // with mem_ready high, so this also clears the counter on entry.
  always_comb begin
    cnt_d = '0;
    if (wait_st && !mem_ready) begin
      if (cnt_q == CNT_MAX) cnt_d = cnt_q;
      else                  cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State register, wait counter and sticky flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (timeout_hit) timeout_q <= 1'b1;
`ifdef ILLEGAL_TRAP_EN
      if (illegal_set) illegal_q <= 1'b1;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
`ifdef ILLEGAL_TRAP_EN
    illegal_set = 1'b0;
`endif
    if (timeout_hit) begin
      state_d = S_TRAP;
    end else begin
      case (state_q)
        S_FETCH:    if (mem_ready) state_d = S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_LOAD, OP_STORE: state_d = S_MEMADR;
            OP_RTYPE:          state_d = S_EXECR;
            OP_ITYPE:          state_d = S_EXECI;
            OP_BR:             state_d = S_BRANCH;
            OP_JAL:            state_d = S_JAL;
            OP_JALR:           state_d = S_JALR1;
            OP_LUI:            state_d = S_LUI;
            OP_AUIPC:          state_d = S_AUIPC;
            default: begin
`ifdef ILLEGAL_TRAP_EN
              state_d     = S_TRAP;
              illegal_set = 1'b1;
`else
              state_d = S_FETCH;
`endif
            end
          endcase
        end
        S_MEMADR:   state_d = opcode[5] ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
        S_MEMWB:    state_d = S_FETCH;
        S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
        S_EXECR:    state_d = S_ALUWB;
        S_EXECI:    state_d = S_ALUWB;
        S_ALUWB:    state_d = S_FETCH;
        S_BRANCH: begin
          state_d = S_FETCH;
`ifdef ILLEGAL_TRAP_EN
          if ((funct3 != F3_BEQ) && (funct3 != F3_BNE)) begin
            state_d     = S_TRAP;
            illegal_set = 1'b1;
          end
`endif
        end
        S_JAL:      state_d = S_ALUWB;
        S_JALR1:    state_d = S_JALR2;
        S_JALR2:    state_d = S_ALUWB;
        S_LUI:      state_d = S_ALUWB;
        S_AUIPC:    state_d = S_ALUWB;
        S_TRAP:     state_d = S_TRAP;
        default:    state_d = S_FETCH;
      endcase
    end
  end

  // Output decode. Enables are gated off while reset is high.
  always_comb begin
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = R_ALUOUT;
    alu_src_a  = A_PC;
    alu_src_b  = B_RS2;
    alu_op     = OP_ADD;
    case (state_q)
      S_FETCH: begin
        alu_src_a  = A_PC;
        alu_src_b  = B_FOUR;
        result_src = R_ALURES;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = A_OLDPC;
        alu_src_b = B_IMM;
      end
      S_MEMADR: begin
        alu_src_a = A_RS1;
        alu_src_b = B_IMM;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        result_src = R_DATA;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = !timeout_hit;
      end
      S_EXECR: begin
        alu_src_a = A_RS1;
        alu_src_b = B_RS2;
        alu_op    = OP_FUNC;
      end
      S_EXECI: begin
        alu_src_a = A_RS1;
        alu_src_b = B_IMM;
        alu_op    = OP_FUNC;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = A_RS1;
        alu_src_b = B_RS2;
        alu_op    = OP_SUB;
        pc_write  = br_taken;
      end
      S_JAL, S_JALR2: begin
        alu_src_a = A_OLDPC;
        alu_src_b = B_FOUR;
        pc_write  = 1'b1;
      end
      S_JALR1: begin
        alu_src_a = A_RS1;
        alu_src_b = B_IMM;
      end
      S_LUI: begin
        alu_src_a = A_ZERO;
        alu_src_b = B_IMM;
      end
      S_AUIPC: begin
        alu_src_a = A_OLDPC;
        alu_src_b = B_IMM;
      end
      default: ;
    endcase
    if (reset) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
    end
  end

  assign halted      = (state_q == S_TRAP);
  assign mem_timeout = timeout_q;
`ifdef ILLEGAL_TRAP_EN
  assign illegal_instr = illegal_q;
`else
  assign illegal_instr = 1'b0;
`endif

endmodule
